// File: rtl/fir_sym_param_if.sv
// Streaming sample, coefficient-load and result signals of the symmetric FIR.
// master drives samples and coefficients; slave is the filter.
interface fir_sym_param_if #(
    parameter int DATA_W = 16,
    parameter int NTAPS  = 32,
    parameter int COEF_W = 20
);
    localparam int AW = $clog2(NTAPS / 2);

    logic                     in_valid;
    logic signed [DATA_W-1:0] in_data;
    logic                     coef_we;
    logic [AW-1:0]            coef_addr;
    logic signed [COEF_W-1:0] coef_wdata;
    logic                     coef_swap;
    logic                     flush;
    logic                     out_valid;
    logic signed [DATA_W-1:0] out_data;
    logic                     out_sat;

    modport master (
        output in_valid,
        output in_data,
        output coef_we,
        output coef_addr,
        output coef_wdata,
        output coef_swap,
        output flush,
        input  out_valid,
        input  out_data,
        input  out_sat
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  coef_we,
        input  coef_addr,
        input  coef_wdata,
        input  coef_swap,
        input  flush,
        output out_valid,
        output out_data,
        output out_sat
    );
endinterface

// File: rtl/fir_sym_param.sv
// Symmetric-coefficient FIR: pre-add, multiply, pipelined adder tree,
// round-half-up and saturate; double-buffered coefficient banks.
module fir_sym_param #(
    parameter int DATA_W = 16,
    parameter int NTAPS  = 32,
    parameter int COEF_W = 20,
    parameter int FRAC   = 16
) (
    input  logic           clk,
    input  logic           rst,
    fir_sym_param_if.slave bus
);
    localparam int HALF   = NTAPS / 2;
    localparam int LOGH   = $clog2(HALF);
    localparam int PRE_W  = DATA_W + 1;
    localparam int PROD_W = PRE_W + COEF_W;
    localparam int ACC_W  = PROD_W + LOGH;
    localparam int RND_W  = ACC_W + 1;
    localparam int LAT    = 3 + LOGH;
    localparam int CLOG_N = $clog2(NTAPS) + 1;
    localparam int CNT_W  = (CLOG_N > 6) ? CLOG_N : 6;

    localparam logic [CNT_W-1:0] FILL_MAX = '1;
    localparam logic [CNT_W-1:0] FILL_REQ = CNT_W'(NTAPS - 1);

    localparam logic signed [RND_W-1:0] RND_HALF =
        RND_W'(1) << (FRAC - 1);
    localparam logic signed [RND_W-1:0] SAT_MAX =
        {{(RND_W - DATA_W + 1){1'b0}}, {(DATA_W - 1){1'b1}}};
    localparam logic signed [RND_W-1:0] SAT_MIN = ~SAT_MAX;

    logic signed [DATA_W-1:0] dl      [NTAPS-1];
    logic signed [DATA_W-1:0] win     [NTAPS];
    logic [CNT_W-1:0]         fill;
    logic                     take;
    logic [LAT-2:0]           vld;

    logic signed [COEF_W-1:0] shd     [HALF];
    logic signed [COEF_W-1:0] shd_nxt [HALF];
    logic signed [COEF_W-1:0] act     [HALF];

    logic signed [PRE_W-1:0]  pre     [HALF];
    logic signed [PROD_W-1:0] prod    [HALF];
    logic signed [ACC_W-1:0]  lvl_in  [LOGH][HALF];
    logic signed [ACC_W-1:0]  tr      [LOGH][HALF];
    logic signed [RND_W-1:0]  rnd;
    logic signed [RND_W-1:0]  shr;
    logic                     ovf_hi;
    logic                     ovf_lo;

    // Window seen by the pre-adders: new sample plus history, history
    // treated as zero when a flush coincides with the sample.
    always_comb begin
        win[0] = bus.in_data;
        for (int j = 1; j < NTAPS; j++) begin
            win[j] = bus.flush ? '0 : dl[j-1];
        end
    end

    // Only samples with a full history behind them enter the pipeline.
    assign take = bus.in_valid && !bus.flush && (fill >= FILL_REQ);

    // Saturating count of accepted samples since reset or flush.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fill <= '0;
        end else if (bus.flush) begin
            fill <= CNT_W'(bus.in_valid);
        end else if (bus.in_valid && fill != FILL_MAX) begin
            fill <= fill + CNT_W'(1);
        end
    end

    // Delay line shifts only on accepted samples; flush clears it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int j = 0; j < NTAPS - 1; j++) dl[j] <= '0;
        end else if (bus.in_valid) begin
            for (int j = 0; j < NTAPS - 1; j++) dl[j] <= win[j];
        end else if (bus.flush) begin
            for (int j = 0; j < NTAPS - 1; j++) dl[j] <= '0;
        end
    end

    // Shadow contents after this cycle's write, so a same-cycle swap
    // picks the write up.
    always_comb begin
        for (int k = 0; k < HALF; k++) shd_nxt[k] = shd[k];
        if (bus.coef_we) shd_nxt[bus.coef_addr] = bus.coef_wdata;
    end

    // Shadow bank takes writes; active bank copies it on swap.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < HALF; k++) begin
                shd[k] <= '0;
                act[k] <= '0;
            end
        end else begin
            for (int k = 0; k < HALF; k++) shd[k] <= shd_nxt[k];
            if (bus.coef_swap) begin
                for (int k = 0; k < HALF; k++) act[k] <= shd_nxt[k];
            end
        end
    end

    // Stage valids: pre-add, multiply, then one per tree level.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld <= '0;
        end else begin
            vld <= {vld[LAT-3:0], take};
        end
    end

    // Fold symmetric taps pairwise before multiplying.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < HALF; k++) pre[k] <= '0;
        end else if (take) begin
            for (int k = 0; k < HALF; k++) begin
                pre[k] <= PRE_W'(win[k]) + PRE_W'(win[NTAPS-1-k]);
            end
        end
    end

    // Products use the active bank as it stands at this edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < HALF; k++) prod[k] <= '0;
        end else if (vld[0]) begin
            for (int k = 0; k < HALF; k++) begin
                prod[k] <= PROD_W'(pre[k]) * PROD_W'(act[k]);
            end
        end
    end

    // Inputs of each tree level: products for the first, previous
    // level's registers for the rest.
    always_comb begin
        for (int l = 0; l < LOGH; l++) begin
            for (int i = 0; i < HALF; i++) lvl_in[l][i] = '0;
        end
        for (int i = 0; i < HALF; i++) lvl_in[0][i] = ACC_W'(prod[i]);
        for (int l = 1; l < LOGH; l++) begin
            for (int i = 0; i < HALF; i++) lvl_in[l][i] = tr[l-1][i];
        end
    end

    // Registered pairwise adder tree, one level per cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int l = 0; l < LOGH; l++) begin
                for (int i = 0; i < HALF; i++) tr[l][i] <= '0;
            end
        end else begin
            for (int l = 0; l < LOGH; l++) begin
                if (vld[l+1]) begin
                    for (int i = 0; i < (HALF >> (l + 1)); i++) begin
                        tr[l][i] <= lvl_in[l][2*i] + lvl_in[l][2*i+1];
                    end
                end
            end
        end
    end

    // Round half toward +inf, then detect out-of-range results.
    always_comb begin
        rnd    = RND_W'(tr[LOGH-1][0]) + RND_HALF;
        shr    = rnd >>> FRAC;
        ovf_hi = shr > SAT_MAX;
        ovf_lo = shr < SAT_MIN;
    end

    // Registered clipped result with its valid and clip flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
            bus.out_sat   <= 1'b0;
        end else begin
            bus.out_valid <= vld[LAT-2];
            bus.out_sat   <= vld[LAT-2] && (ovf_hi || ovf_lo);
            if (vld[LAT-2]) begin
                if (ovf_hi) begin
                    bus.out_data <= SAT_MAX[DATA_W-1:0];
                end else if (ovf_lo) begin
                    bus.out_data <= SAT_MIN[DATA_W-1:0];
                end else begin
                    bus.out_data <= shr[DATA_W-1:0];
                end
            end
        end
    end
endmodule

// File: tb/tb_fir_sym_param.sv
// Bench for fir_sym_param: direct-convolution reference model with a
// per-cycle compare process, plus hand-computed directed cases.
module tb_fir_sym_param;
    localparam int DATA_W = 16;
    localparam int NTAPS  = 32;
    localparam int COEF_W = 20;
    localparam int FRAC   = 16;
    localparam int HALF   = NTAPS / 2;
    localparam int AW     = $clog2(HALF);
    localparam int LAT    = 3 + AW;
    localparam longint MAXV = 32767;
    localparam longint MINV = -32768;

    typedef struct {
        int     due;
        longint data;
        bit     sat;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    int     shd [HALF];
    int     act [HALF];
    longint hist [NTAPS-1];
    int     fill;
    exp_t   exp_q [$];

    int     cap_cyc [$];
    longint cap_dat [$];
    bit     cap_sat [$];
    int     acc_cyc [$];
    int     cset [HALF];

    fir_sym_param_if #(
        .DATA_W(DATA_W), .NTAPS(NTAPS), .COEF_W(COEF_W)
    ) bus ();

    fir_sym_param #(
        .DATA_W(DATA_W), .NTAPS(NTAPS),
        .COEF_W(COEF_W), .FRAC(FRAC)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(string nm, longint got, longint want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0d want=%0d", nm, cyc, got, want);
        end
    endfunction

    function automatic int rnd_s(int w);
        return int'($urandom_range(0, (1 << w) - 1)) - (1 << (w - 1));
    endfunction

    function automatic void model_reset();
        for (int k = 0; k < HALF; k++) begin
            shd[k] = 0;
            act[k] = 0;
        end
        for (int i = 0; i < NTAPS - 1; i++) hist[i] = 0;
        fill = 0;
        exp_q.delete();
    endfunction

    // y = sum c[k]*(x[n-k]+x[n-31+k]), rounded and clipped.
    function automatic void model_step(int c, bit v, int d, bit we,
                                       int a, int wd, bit sw, bit fl);
        longint x [NTAPS];
        longint acc;
        longint r;
        exp_t   e;
        int     prior;
        if (we) shd[a] = wd;
        if (sw) for (int k = 0; k < HALF; k++) act[k] = shd[k];
        if (fl) for (int i = 0; i < NTAPS - 1; i++) hist[i] = 0;
        prior = fl ? 0 : fill;
        if (v) begin
            x[0] = d;
            for (int j = 1; j < NTAPS; j++) x[j] = hist[j-1];
            acc = 0;
            for (int k = 0; k < HALF; k++) begin
                acc += longint'(act[k]) * (x[k] + x[NTAPS-1-k]);
            end
            r = (acc + (longint'(1) <<< (FRAC - 1))) >>> FRAC;
            e.due  = c + LAT;
            e.sat  = (r > MAXV) || (r < MINV);
            e.data = (r > MAXV) ? MAXV : ((r < MINV) ? MINV : r);
            if (prior >= NTAPS - 1) exp_q.push_back(e);
            for (int i = NTAPS - 2; i > 0; i--) hist[i] = hist[i-1];
            hist[0] = d;
            fill = prior + 1;
        end else if (fl) begin
            fill = 0;
        end
    endfunction

    task automatic drive(bit v, int d, bit we, int a, int wd,
                         bit sw, bit fl);
        bus.in_valid   = v;
        bus.in_data    = DATA_W'(d);
        bus.coef_we    = we;
        bus.coef_addr  = AW'(a);
        bus.coef_wdata = COEF_W'(wd);
        bus.coef_swap  = sw;
        bus.flush      = fl;
        if (rst) model_step(cyc, v, d, we, a, wd, sw, fl);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(int n);
        repeat (n) drive(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic load_and_swap();
        for (int k = 0; k < HALF - 1; k++) drive(0, 0, 1, k, cset[k], 0, 0);
        drive(0, 0, 1, HALF - 1, cset[HALF-1], 1, 0);
    endtask

    task automatic clear_caps();
        cap_cyc.delete();
        cap_dat.delete();
        cap_sat.delete();
        acc_cyc.delete();
    endtask

    // 31 zeros, 1600, 31 zeros; gap-1 idle cycles after each sample.
    task automatic impulse_run(string tag, int gap);
        longint want;
        drive(0, 0, 0, 0, 0, 0, 1);
        clear_caps();
        for (int i = 0; i < 63; i++) begin
            if (i >= 31) acc_cyc.push_back(cyc);
            drive(1, (i == 31) ? 1600 : 0, 0, 0, 0, 0, 0);
            if (gap > 1) idle(gap - 1);
        end
        idle(LAT + 4);
        chk({tag, "_count"}, cap_dat.size(), 32);
        for (int i = 0; i < 32 && i < cap_dat.size(); i++) begin
            want = (i < 16) ? 100 * (i + 1) : 100 * (32 - i);
            chk({tag, "_data"}, cap_dat[i], want);
            chk({tag, "_lag"}, cap_cyc[i] - acc_cyc[i], LAT);
        end
    endtask

    task automatic dc_run(string tag, int d, longint wd, bit ws);
        for (int i = 0; i < 40; i++) drive(1, d, 0, 0, 0, 0, 0);
        idle(LAT + 3);
        chk({tag, "_seen"}, cap_dat.size() > 0, 1);
        if (cap_dat.size() > 0) begin
            chk({tag, "_data"}, cap_dat[$], wd);
            chk({tag, "_sat"}, cap_sat[$], ws);
        end
    endtask

    // Reference compare on every cycle outside reset.
    always @(negedge clk) begin : cmp
        exp_t e;
        if (rst) begin
            while (exp_q.size() > 0 && exp_q[0].due < cyc) begin
                chk("pulse_missed", cyc, exp_q[0].due);
                void'(exp_q.pop_front());
            end
            if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
                e = exp_q.pop_front();
                chk("out_valid", bus.out_valid, 1);
                chk("out_data", $signed(bus.out_data), e.data);
                chk("out_sat", bus.out_sat, e.sat);
            end else begin
                chk("idle_valid", bus.out_valid, 0);
                chk("idle_sat", bus.out_sat, 0);
            end
            if (bus.out_valid) begin
                cap_cyc.push_back(cyc);
                cap_dat.push_back($signed(bus.out_data));
                cap_sat.push_back(bus.out_sat);
            end
        end
    end

    initial begin
        int cs;
        int cf;
        int n;
        bit zero_ok;
        #1;
        rst = 1'b0;
        model_reset();
        repeat (8) begin
            bus.in_valid   = 1'($urandom);
            bus.in_data    = DATA_W'($urandom);
            bus.coef_we    = 1'($urandom);
            bus.coef_addr  = AW'($urandom);
            bus.coef_wdata = COEF_W'($urandom);
            bus.coef_swap  = 1'($urandom);
            bus.flush      = 1'($urandom);
            @(negedge clk);
            chk("rst_valid", bus.out_valid, 0);
            chk("rst_data", bus.out_data, 0);
            chk("rst_sat", bus.out_sat, 0);
            @(posedge clk);
            #1;
        end
        bus.in_valid  = 1'b0;
        bus.coef_we   = 1'b0;
        bus.coef_swap = 1'b0;
        bus.flush     = 1'b0;
        rst = 1'b1;
        idle(10);
        @(negedge clk);
        chk("rel_data", bus.out_data, 0);
        @(posedge clk);
        #1;

        for (int k = 0; k < HALF; k++) cset[k] = (k + 1) << 12;
        load_and_swap();
        impulse_run("impulse", 1);
        impulse_run("gapped", 3);

        for (int k = 0; k < HALF; k++) cset[k] = 32'h10000;
        load_and_swap();
        drive(0, 0, 0, 0, 0, 0, 1);
        clear_caps();
        dc_run("sat_pos", 32767, 32767, 1);
        dc_run("sat_neg", -32768, -32768, 1);
        dc_run("dc_1000", 1000, 32000, 0);

        for (int k = 0; k < HALF; k++) cset[k] = (k == 0) ? 32'h8000 : 0;
        load_and_swap();
        drive(0, 0, 0, 0, 0, 0, 1);
        clear_caps();
        for (int i = 0; i < 31; i++) drive(1, 0, 0, 0, 0, 0, 0);
        drive(1, 3, 0, 0, 0, 0, 0);
        drive(1, -3, 0, 0, 0, 0, 0);
        idle(LAT + 3);
        chk("round_count", cap_dat.size(), 2);
        if (cap_dat.size() == 2) begin
            chk("round_pos", cap_dat[0], 2);
            chk("round_neg", cap_dat[1], -1);
        end

        for (int k = 0; k < HALF; k++) cset[k] = (k + 1) << 12;
        load_and_swap();
        drive(0, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 40; i++) drive(1, rnd_s(12), 0, 0, 0, 0, 0);
        for (int k = 0; k < HALF; k++) drive(1, rnd_s(12), 1, k, 0, 0, 0);
        clear_caps();
        cs = cyc;
        drive(1, rnd_s(12), 0, 0, 0, 1, 0);
        for (int i = 0; i < 20; i++) drive(1, rnd_s(12), 0, 0, 0, 0, 0);
        idle(LAT + 3);
        n = 0;
        zero_ok = 1'b1;
        foreach (cap_cyc[i]) begin
            if (cap_cyc[i] >= cs + LAT) begin
                n++;
                if (cap_dat[i] != 0) zero_ok = 1'b0;
            end
        end
        chk("swap_zero_count", n, 21);
        chk("swap_zero_data", zero_ok, 1);

        load_and_swap();
        for (int i = 0; i < 40; i++) drive(1, rnd_s(12), 0, 0, 0, 0, 0);
        clear_caps();
        cf = cyc;
        drive(0, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 40; i++) drive(1, rnd_s(12), 0, 0, 0, 0, 0);
        idle(LAT + 3);
        n = 0;
        foreach (cap_cyc[i]) if (cap_cyc[i] >= cf + LAT) n++;
        chk("flush_resume", n, 9);

        for (int t = 0; t < 2000; t++) begin
            drive(($urandom_range(0, 3) != 0),
                  rnd_s(DATA_W) >>> $urandom_range(0, 8),
                  ($urandom_range(0, 7) == 0),
                  int'($urandom_range(0, HALF - 1)),
                  rnd_s(COEF_W) >>> $urandom_range(0, 10),
                  ($urandom_range(0, 63) == 0),
                  ($urandom_range(0, 199) == 0));
        end

        for (int i = 0; i < 40; i++) drive(1, rnd_s(10), 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) drive(1, rnd_s(10), 0, 0, 0, 0, 0);
        rst = 1'b0;
        model_reset();
        idle(3);
        rst = 1'b1;
        clear_caps();
        for (int i = 0; i < 20; i++) drive(1, rnd_s(10), 0, 0, 0, 0, 0);
        idle(LAT + 3);
        chk("rst_mid_quiet", cap_dat.size(), 0);
        chk("pending", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/fir_sym_param.md
FIR_SYM_PARAM -- requirements
Module: fir_sym_param

Interface
REQ-001 Parameter DATA_W, default 16: sample width (signed two's complement) of input and output.
REQ-002 Parameter NTAPS, default 32: filter length; even power of two, >= 4; coefficients are symmetric, so NTAPS/2 unique values.
REQ-003 Parameter COEF_W, default 20: signed coefficient width.
REQ-004 Parameter FRAC, default 16: fractional bits of coefficients; 1.0 = 2^FRAC.
REQ-005 Port clk  in  1: single clock; all state updates on rising edge.
REQ-006 Port rst  in  1: reset, asynchronous, active-low.
REQ-007 Port in_valid  in  1: in_data holds a sample this cycle.
REQ-008 Port in_data  in  DATA_W: signed input sample.
REQ-009 Port coef_we  in  1: write coef_wdata into shadow coefficient slot coef_addr.
REQ-010 Port coef_addr  in  log2(NTAPS/2): shadow slot index k.
REQ-011 Port coef_wdata  in  COEF_W: signed coefficient value.
REQ-012 Port coef_swap  in  1: copy the whole shadow bank into the active bank.
REQ-013 Port flush  in  1: synchronous clear of the delay line and the fill counter.
REQ-014 Port out_valid  out  1: out_data/out_sat are valid this cycle.
REQ-015 Port out_data  out  DATA_W: signed filter output.
REQ-016 Port out_sat  out  1: out_data was clipped by saturation.

Function
REQ-017 y[n] SHALL equal sum over k=0..NTAPS/2-1 of c[k]*(x[n-k] + x[n-(NTAPS-1-k)]), with c taken from the active bank.
REQ-018 Delay line SHALL shift only on cycles with in_valid=1; with in_valid=0 it holds.
REQ-019 Pipeline SHALL be: pre-add register, multiply register, log2(NTAPS/2) adder-tree registers, round/saturate register; latency L = 3 + log2(NTAPS/2), i.e. 7 at the defaults.
REQ-020 out_valid SHALL pulse exactly L cycles after each accepted in_valid cycle and be 0 otherwise; gaps in in_valid SHALL be preserved cycle-for-cycle.
REQ-021 Internal widths SHALL be lossless: pre-add DATA_W+1, product DATA_W+1+COEF_W, accumulator DATA_W+1+COEF_W+log2(NTAPS/2).
REQ-022 Rounding SHALL add 2^(FRAC-1) to the accumulator, then arithmetic-shift right by FRAC (round half toward +infinity).
REQ-023 Result SHALL saturate to [-2^(DATA_W-1), 2^(DATA_W-1)-1]; out_sat = 1 exactly when clipping occurred, qualified by out_valid.
REQ-024 A 6-bit-minimum saturating fill counter SHALL count accepted samples; out_valid SHALL be suppressed for samples accepted while fewer than NTAPS-1 earlier samples are in the delay line.
REQ-025 coef_we SHALL write shadow only; the active bank SHALL be unaffected until coef_swap.
REQ-026 coef_swap SHALL update the active bank at that edge; the multiply stage uses the new values from the next cycle onward, and in-flight products are not recomputed.
REQ-027 When coef_we and coef_swap are asserted in the same cycle, the active bank SHALL receive the shadow contents including that cycle's write.
REQ-028 flush SHALL zero the delay line and the fill counter at the edge, without altering coefficients or results already in the pipeline; flush together with in_valid SHALL load that sample into an otherwise zero line, with fill count 1.

Reset
REQ-029 While rst=0: delay line, pipeline registers, fill counter, out_valid, out_data and out_sat SHALL be 0, and both coefficient banks SHALL be 0.
REQ-030 Reset assertion mid-stream SHALL discard all in-flight samples; no out_valid pulse may follow release until a fresh fill completes.

Verification
REQ-031 Reset: rst=0 with random inputs -> out_valid=0, out_data=0, out_sat=0; after release with no in_valid -> outputs stay 0.
REQ-032 Impulse: c[k]=(k+1)<<12 then swap, 31 zeros then 1600 then zeros, all back-to-back -> out_data sequence 100,200,...,1600,1600,...,100 (32 values), first value 7 cycles after the 1600 is accepted.
REQ-033 Saturation: all c=0x10000, DC 32767 stream -> out_data=32767 with out_sat=1; DC -32768 -> -32768 with out_sat=1; DC 1000 -> 32000 with out_sat=0 once filled.
REQ-034 Rounding: c[0]=0x8000, others 0, filled with zeros, then input 3 -> out 2; input -3 -> out -1.
REQ-035 Gapped input: REQ-032 stimulus with in_valid high every 3rd cycle -> identical out_data sequence, each pulse 7 cycles after its input.
REQ-036 Swap/flush: coef_swap to all-zero coefficients mid-stream -> outputs from the swap-aligned sample onward are 0; flush mid-stream -> out_valid is absent for the next 31 accepted samples, then resumes.
